// File: rtl/io_port_controller_pkg.sv
// Shared widths, parameter defaults and interrupt FSM encoding for the IO port controller.
package io_port_controller_pkg;
  localparam int DATA_W             = 16;
  localparam int DEF_OUT_DEPTH      = 4;
  localparam int DEF_HOLDOFF_CYCLES = 4;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_PULSE   = 2'd1,
    IRQ_HOLDOFF = 2'd2
  } irq_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/io_port_controller_if.sv
// Processor / external-side signal bundle; slave is the controller's view.
interface io_port_controller_if;
  import io_port_controller_pkg::*;

  word_t outPortData;
  logic  outSignalEn;
  logic  inPortRead;
  word_t inPortData;
  logic  interruptSignal;
  word_t extOutData;
  logic  extOutValid;
  logic  extOutReady;
  word_t extInData;
  logic  extInValid;
  logic  extInReady;
  logic  overflow;

  modport master (
    output outPortData, outSignalEn, inPortRead, extOutReady, extInData, extInValid,
    input  inPortData, interruptSignal, extOutData, extOutValid, extInReady, overflow
  );

  modport slave (
    input  outPortData, outSignalEn, inPortRead, extOutReady, extInData, extInValid,
    output inPortData, interruptSignal, extOutData, extOutValid, extInReady, overflow
  );
endinterface

// File: rtl/io_out_fifo.sv
// OUT-word FIFO: head presented combinationally, words pushed while full without a pop are dropped.
module io_out_fifo
  import io_port_controller_pkg::*;
#(
  parameter int DEPTH = DEF_OUT_DEPTH
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  word_t push_data,
  input  logic  pop_ready,
  output word_t head,
  output logic  head_valid,
  output logic  overflow
);
  localparam int AW = clog2_min1(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  word_t         mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, pop, wr;

  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr];
  assign full       = (count == FULL);
  assign pop        = head_valid && pop_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign wr         = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      if (wr && !pop)      count <= count + CW'(1);
      else if (pop && !wr) count <= count - CW'(1);
      if (push && !wr) overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/io_port_controller.sv
// IO port controller: OUT FIFO, single-word IN hold register and rate-limited input interrupt.
module io_port_controller
  import io_port_controller_pkg::*;
#(
  parameter int OUT_DEPTH      = DEF_OUT_DEPTH,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input logic                 clk,
  input logic                 reset,
  io_port_controller_if.slave bus
);
  localparam int HW = clog2_min1(HOLDOFF_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

  io_out_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (bus.outSignalEn),
    .push_data  (bus.outPortData),
    .pop_ready  (bus.extOutReady),
    .head       (bus.extOutData),
    .head_valid (bus.extOutValid),
    .overflow   (bus.overflow)
  );

  word_t in_hold;
  logic  in_hold_valid, capture;

  assign capture        = bus.extInValid && !in_hold_valid;
  assign bus.extInReady = !in_hold_valid;
  assign bus.inPortData = in_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_hold       <= '0;
      in_hold_valid <= 1'b0;
    end else if (capture) begin
      in_hold       <= bus.extInData;
      in_hold_valid <= 1'b1;
    end else if (bus.inPortRead) begin
      in_hold_valid <= 1'b0;
    end
  end

  irq_state_t    state, state_n;
  logic          pending, pending_n, irq;
  logic [HW-1:0] hcnt, hcnt_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IRQ_IDLE;
      pending <= 1'b0;
      hcnt    <= '0;
      irq     <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      hcnt    <= hcnt_n;
      irq     <= (state_n == IRQ_PULSE);
    end
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    hcnt_n    = hcnt;
    case (state)
      IRQ_IDLE: if (capture) state_n = IRQ_PULSE;
      IRQ_PULSE: begin
        state_n = IRQ_HOLDOFF;
        hcnt_n  = '0;
        if (capture) pending_n = 1'b1;
      end
      IRQ_HOLDOFF: begin
        if (hcnt == HOLD_LAST) begin
          // A capture on the exit edge is not lost: it either drives this pulse or stays queued.
          if (pending || capture) begin
            state_n   = IRQ_PULSE;
            pending_n = pending && capture;
          end else begin
            state_n = IRQ_IDLE;
          end
        end else begin
          hcnt_n = hcnt + HW'(1);
          if (capture) pending_n = 1'b1;
        end
      end
      default: state_n = IRQ_IDLE;
    endcase
  end

  assign bus.interruptSignal = irq;
endmodule

// File: tb/tb_io_port_controller.sv
// Directed bench for io_port_controller: FIFO ordering/overflow, IN hold handshake, interrupt timing and reset.
module tb_io_port_controller;
  import io_port_controller_pkg::*;

  localparam int H = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  io_port_controller_if bus();

  io_port_controller #(.OUT_DEPTH(4), .HOLDOFF_CYCLES(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  // Called just after an edge: reset is pulsed between edges, then one clean cycle.
  task automatic rst_pulse();
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    tick();
  endtask

  initial begin
    bus.outPortData = '0;
    bus.outSignalEn = 1'b0;
    bus.inPortRead  = 1'b0;
    bus.extOutReady = 1'b0;
    bus.extInData   = '0;
    bus.extInValid  = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", bus.extOutValid, 1'b0);
    chk("rst_inrdy", bus.extInReady, 1'b1);
    chk("rst_irq", bus.interruptSignal, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    chk("rst_indata", bus.inPortData, 16'h0000);
    reset = 1'b1;
    tick();

    // Two OUTs, stalled consumer, then in-order delivery
    bus.outSignalEn = 1'b1;
    bus.outPortData = 16'h1111;
    tick();
    chk("A_valid1", bus.extOutValid, 1'b1);
    chk("A_head1", bus.extOutData, 16'h1111);
    bus.outPortData = 16'h2222;
    tick();
    bus.outSignalEn = 1'b0;
    tick(); tick(); tick();
    chk("A_stall_head", bus.extOutData, 16'h1111);
    bus.extOutReady = 1'b1;
    tick();
    chk("A_head2", bus.extOutData, 16'h2222);
    chk("A_valid2", bus.extOutValid, 1'b1);
    tick();
    chk("A_empty", bus.extOutValid, 1'b0);
    bus.extOutReady = 1'b0;

    // Overflow: five OUTs into a four-deep FIFO
    bus.outSignalEn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.outPortData = 16'hA000 + 16'(i);
      tick();
    end
    chk("B_ovf_before", bus.overflow, 1'b0);
    bus.outPortData = 16'hA004;
    tick();
    bus.outSignalEn = 1'b0;
    chk("B_ovf_set", bus.overflow, 1'b1);
    bus.extOutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("B_drain", bus.extOutData, 16'hA000 + 16'(i));
      tick();
    end
    chk("B_empty", bus.extOutValid, 1'b0);
    chk("B_ovf_sticky", bus.overflow, 1'b1);
    bus.extOutReady = 1'b0;

    // Full FIFO with simultaneous push and pop
    rst_pulse();
    chk("C_ovf_cleared", bus.overflow, 1'b0);
    bus.outSignalEn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.outPortData = 16'hB000 + 16'(i);
      tick();
    end
    bus.outPortData = 16'hB004;
    bus.extOutReady = 1'b1;
    tick();
    bus.outSignalEn = 1'b0;
    chk("C_ovf_clear", bus.overflow, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk("C_drain", bus.extOutData, 16'hB000 + 16'(i));
      tick();
    end
    chk("C_empty", bus.extOutValid, 1'b0);
    // Empty FIFO: pop request ignored, push performed
    bus.outSignalEn = 1'b1;
    bus.outPortData = 16'hC000;
    tick();
    bus.outSignalEn = 1'b0;
    bus.extOutReady = 1'b0;
    chk("C_emptypush_valid", bus.extOutValid, 1'b1);
    chk("C_emptypush_head", bus.extOutData, 16'hC000);

    // IN capture, one-cycle interrupt, second word held off until consumed
    rst_pulse();
    bus.extInData  = 16'h00FF;
    bus.extInValid = 1'b1;
    tick();
    chk("D_indata", bus.inPortData, 16'h00FF);
    chk("D_inrdy", bus.extInReady, 1'b0);
    chk("D_irq_on", bus.interruptSignal, 1'b1);
    bus.extInData = 16'h1234;
    tick();
    chk("D_irq_off", bus.interruptSignal, 1'b0);
    chk("D_hold1", bus.inPortData, 16'h00FF);
    tick();
    chk("D_hold2", bus.inPortData, 16'h00FF);
    bus.inPortRead = 1'b1;
    tick();
    bus.inPortRead = 1'b0;
    chk("D_rdy_after_read", bus.extInReady, 1'b1);
    chk("D_persist", bus.inPortData, 16'h00FF);
    tick();
    bus.extInValid = 1'b0;
    chk("D_second", bus.inPortData, 16'h1234);
    chk("D_second_rdy", bus.extInReady, 1'b0);

    // Capture during holdoff yields exactly one extra pulse H+1 cycles later
    rst_pulse();
    bus.extInData  = 16'h5A5A;
    bus.extInValid = 1'b1;
    tick();
    chk("E_irq1", bus.interruptSignal, 1'b1);
    bus.extInValid = 1'b0;
    bus.inPortRead = 1'b1;
    tick();
    chk("E_irq2", bus.interruptSignal, 1'b0);
    bus.inPortRead = 1'b0;
    bus.extInData  = 16'h5555;
    bus.extInValid = 1'b1;
    tick();
    bus.extInValid = 1'b0;
    chk("E_cap", bus.inPortData, 16'h5555);
    chk("E_irq3", bus.interruptSignal, 1'b0);
    for (int k = 4; k <= 16; k++) begin
      tick();
      chk($sformatf("E_irq_k%0d", k), bus.interruptSignal, 32'(k == H + 2));
    end

    // Reset during a pulse with a pending capture queued
    rst_pulse();
    bus.extInData  = 16'h0A0A;
    bus.extInValid = 1'b1;
    tick();
    bus.extInValid = 1'b0;
    bus.inPortRead = 1'b1;
    tick();
    bus.inPortRead = 1'b0;
    bus.extInData  = 16'h0B0B;
    bus.extInValid = 1'b1;
    tick();
    bus.extInValid = 1'b0;
    bus.inPortRead = 1'b1;
    tick();
    bus.inPortRead = 1'b0;
    tick();
    bus.extInData  = 16'h0C0C;
    bus.extInValid = 1'b1;
    tick();
    bus.extInValid = 1'b0;
    chk("F_pulse", bus.interruptSignal, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("F_irq_drop", bus.interruptSignal, 1'b0);
    chk("F_inrdy", bus.extInReady, 1'b1);
    #2 reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("F_no_pulse", bus.interruptSignal, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
